scratchpad_req_ctrl: RTL
========================

SCRATCHPAD_REQ_CTRL -- requirements
Module: scratchpad_req_ctrl

Interface
REQ-001 SHALL have parameter CHUNK_SIZE, default 4, bytes per scratchpad chunk.
REQ-002 SHALL have parameter NUM_CHUNKS, default 2, number of chunks; SIZE = CHUNK_SIZE*NUM_CHUNKS.
REQ-003 SHALL have parameter SCRATCHPAD_BASE, default 16, first byte address of the scratchpad window.
REQ-004 SHALL have one clock; reset is asynchronous and active-high.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 req_valid  in  1  request present.
REQ-008 req_ready  out  1  request accepted when high with req_valid.
REQ-009 req_write  in  1  1 = store, 0 = load.
REQ-010 req_addr  in  64  byte address.
REQ-011 req_len  in  2  00 byte, 01 half, 10 word, 11 double.
REQ-012 req_wdata  in  64  store data, little-endian, low bytes significant.
REQ-013 resp_valid  out  1  response present.
REQ-014 resp_ready  in  1  response consumed when high with resp_valid.
REQ-015 resp_rdata  out  64  load data, zero-extended to 64 bits; 0 for stores and errors.
REQ-016 resp_err  out  1  request rejected, no scratchpad access.
REQ-017 spad_en, spad_write  out  1 each  scratchpad enable and write strobe.
REQ-018 spad_addr  out  64; spad_len  out  2; spad_wdata  out  64  scratchpad command fields.
REQ-019 spad_rdata  in  64  scratchpad read data, valid the cycle after spad_en.
REQ-020 err_count  out  16  saturating count of error responses.

Function
REQ-021 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP.
REQ-022 IDLE: req_ready=1; on req_valid, latch write/addr/len/wdata; error -> RESP, else -> ISSUE.
REQ-023 Error: req_addr < SCRATCHPAD_BASE, or (req_addr - SCRATCHPAD_BASE) + (1<<req_len) > SIZE, evaluated at 65-bit width so no wrap-around.
REQ-024 ISSUE: spad_en=1 for exactly one cycle with latched fields; -> WAIT.
REQ-025 spad_addr SHALL equal the latched req_addr unmodified; spad_* SHALL be 0 outside ISSUE.
REQ-026 WAIT: capture spad_rdata masked to (1<<len) bytes for loads, 0 for stores; -> RESP.
REQ-027 RESP: resp_valid=1, fields stable; on resp_ready -> IDLE; req_ready=0 in all states but IDLE.
REQ-028 Latency: a valid access accepted at edge N asserts resp_valid after edge N+3; an error asserts it after edge N+1.
REQ-029 err_count SHALL increment once per error response, when it enters RESP, and saturate at 0xFFFF.
REQ-030 Only one request SHALL be outstanding; no new request is accepted in the cycle resp handshake completes.

Reset
REQ-031 rst SHALL force state IDLE immediately; resp_valid, resp_err, resp_rdata, spad_*, err_count = 0; req_ready = 1 once rst deasserts.
REQ-032 Reset mid-operation SHALL abandon the request with no response; a write in ISSUE may or may not have completed.

Configuration
REQ-033 Macro SCRATCHPAD_REQ_CTRL_ALIGN_CHECK_EN defined: req_addr not a multiple of (1<<req_len) SHALL also be an error.
REQ-034 Macro undefined: alignment SHALL be ignored; only the range check applies.

Verification
REQ-035 Store word 0xDEADBEEF at 16, then load word at 16 -> resp_rdata 0x00000000DEADBEEF, resp_err 0, resp_valid 3 cycles after accept.
REQ-036 Load byte at 8 -> resp_err 1 one cycle after accept, spad_en never high, err_count 1.
REQ-037 Load double at 20 (end 28 > 24) -> resp_err 1; load double at 16 -> resp_err 0.
REQ-038 Load half at 17 -> resp_err 1 with ALIGN_CHECK_EN, resp_err 0 and spad_en pulse without it.
REQ-039 Hold resp_ready low 5 cycles -> resp_valid, resp_rdata stable, req_ready 0 throughout.
REQ-040 Assert rst during ISSUE -> same cycle spad_en 0, resp_valid 0; next request after release completes normally.

Source files
------------

// File: rtl/scratchpad_req_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : scratchpad_req_ctrl
// Purpose  : Single-outstanding request controller that range-checks accesses
//            and forwards them to a scratchpad. Optional alignment check is
//            enabled by defining SCRATCHPAD_REQ_CTRL_ALIGN_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module scratchpad_req_ctrl #(
    parameter int unsigned   CHUNK_SIZE      = 4,
    parameter int unsigned   NUM_CHUNKS      = 2,
    parameter logic [63:0]   SCRATCHPAD_BASE = 64'd16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [1:0]  req_len,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    output logic        spad_en,
    output logic        spad_write,
    output logic [63:0] spad_addr,
    output logic [1:0]  spad_len,
    output logic [63:0] spad_wdata,
    input  logic [63:0] spad_rdata,
    output logic [15:0] err_count
);

    localparam logic [64:0] SIZE_W = 65'(CHUNK_SIZE * NUM_CHUNKS);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]  state_q, state_d;
    logic        wr_q, wr_d;
    logic [63:0] addr_q, addr_d;
    logic [1:0]  len_q, len_d;
    logic [63:0] wdata_q, wdata_d;
    logic        err_q, err_d;
    logic [63:0] rdata_q, rdata_d;
    logic [15:0] err_count_q, err_count_d;

    logic [64:0] w_len_bytes;
    logic [64:0] w_end;
    logic        w_range_err;
    logic        w_err;
    logic [63:0] w_rdata_masked;

    // Offset arithmetic is done at 65 bits so huge addresses cannot wrap into range.
    assign w_len_bytes = 65'd1 << req_len;
    assign w_end       = ({1'b0, req_addr} - {1'b0, SCRATCHPAD_BASE}) + w_len_bytes;
    assign w_range_err = (req_addr < SCRATCHPAD_BASE) || (w_end > SIZE_W);

`ifdef SCRATCHPAD_REQ_CTRL_ALIGN_CHECK_EN
    logic [2:0] w_align_mask;
    assign w_align_mask = 3'(w_len_bytes - 65'd1);
    assign w_err        = w_range_err || ((req_addr[2:0] & w_align_mask) != 3'd0);
`else
    assign w_err        = w_range_err;
`endif

    always_comb begin
        w_rdata_masked = 64'd0;
        case (len_q)
            2'd0:    w_rdata_masked = {56'd0, spad_rdata[7:0]};
            2'd1:    w_rdata_masked = {48'd0, spad_rdata[15:0]};
            2'd2:    w_rdata_masked = {32'd0, spad_rdata[31:0]};
            default: w_rdata_masked = spad_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            wr_q        <= 1'b0;
            addr_q      <= 64'd0;
            len_q       <= 2'd0;
            wdata_q     <= 64'd0;
            err_q       <= 1'b0;
            rdata_q     <= 64'd0;
            err_count_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            wdata_q     <= wdata_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            err_count_q <= err_count_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        len_d       = len_q;
        wdata_d     = wdata_q;
        err_d       = err_q;
        rdata_d     = rdata_q;
        err_count_d = err_count_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    wr_d    = req_write;
                    addr_d  = req_addr;
                    len_d   = req_len;
                    wdata_d = req_wdata;
                    err_d   = w_err;
                    rdata_d = 64'd0;
                    if (w_err) begin
                        state_d = S_RESP;
                        if (err_count_q != 16'hFFFF) begin
                            err_count_d = err_count_q + 16'd1;
                        end
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                rdata_d = wr_q ? 64'd0 : w_rdata_masked;
                state_d = S_RESP;
            end
            default: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        req_ready  = (state_q == S_IDLE);
        spad_en    = (state_q == S_ISSUE);
        spad_write = spad_en & wr_q;
        spad_addr  = spad_en ? addr_q  : 64'd0;
        spad_len   = spad_en ? len_q   : 2'd0;
        spad_wdata = spad_en ? wdata_q : 64'd0;
        resp_valid = (state_q == S_RESP);
        resp_err   = resp_valid & err_q;
        resp_rdata = resp_valid ? rdata_q : 64'd0;
        err_count  = err_count_q;
    end

endmodule
`default_nettype wire
